uart_top: RTL and testbench

- Full-duplex UART: 8N-style asynchronous serial transmitter and receiver sharing one system clock.
- Parallel side uses a ready/empty handshake; serial side drives `o_tx` and samples `i_rx` at a fixed integer baud divisor.
- Sits between chip-internal logic and the external serial pins.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_cnt.sv | 30 +++
 rtl/uart_top.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_top.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART: state encoding used by both the transmit
// and receive state machines, and the mid-bit sampling offset helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Offset from a detected start edge to the centre of the start bit
    function automatic int mid_bit(input int clk_size);
        return clk_size / 2;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud interval down-counter. A load reprograms the interval; the counter then
// runs down to zero and parks there, raising tick while it sits at zero.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int WIDTH_CLK = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH_CLK-1:0] load_val,
    output logic                 tick
);

    logic [WIDTH_CLK-1:0] count;

    // Load takes priority; otherwise count down and hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/uart_top.sv
// Full-duplex UART: independent transmitter and receiver sharing one clock,
// each paced by its own uart_baud_cnt instance.
// Optional build macro UART_FRAME_CHECK_EN adds o_ferr and drops frames whose
// stop sample is low; without it every frame is delivered.
module uart_top
    import uart_pkg::*;
#(
    parameter int WIDTH_DATA = 8,
    parameter int NB_STOP    = 2,
    parameter int WIDTH_CLK  = 9,
    parameter int CLK_SIZE   = 434
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_rx,
    output logic                  o_tx,
    output logic [WIDTH_DATA-1:0] o_data,
    output logic                  o_rdy,
    input  logic                  i_re,
    output logic                  o_mty,
    input  logic                  i_we,
    input  logic [WIDTH_DATA-1:0] i_data
`ifdef UART_FRAME_CHECK_EN
    ,
    output logic                  o_ferr
`endif
);

    localparam int WIDTH_BIT  = $clog2(WIDTH_DATA + 1);
    localparam int WIDTH_STOP = $clog2(NB_STOP + 1);
    localparam logic [WIDTH_CLK-1:0]  BIT_LOAD  = WIDTH_CLK'(CLK_SIZE - 1);
    localparam logic [WIDTH_CLK-1:0]  MID_LOAD  = WIDTH_CLK'(mid_bit(CLK_SIZE) - 1);
    localparam logic [WIDTH_BIT-1:0]  LAST_BIT  = WIDTH_BIT'(WIDTH_DATA - 1);
    localparam logic [WIDTH_STOP-1:0] LAST_STOP = WIDTH_STOP'(NB_STOP - 1);

    // ---------------------------------------------------------------- TX
    uart_state_t           tx_state, tx_state_next;
    logic [WIDTH_DATA-1:0] tx_shift, tx_shift_next;
    logic [WIDTH_BIT-1:0]  tx_bit_cnt, tx_bit_next;
    logic [WIDTH_STOP-1:0] tx_stop_cnt, tx_stop_next;
    logic                  tx_line, tx_line_next;
    logic                  tx_load;
    logic                  tx_tick;

    uart_baud_cnt #(.WIDTH_CLK(WIDTH_CLK)) u_tx_baud (
        .clk      (i_clk),
        .rst_n    (i_nrst),
        .load     (tx_load),
        .load_val (BIT_LOAD),
        .tick     (tx_tick)
    );

    // Transmit state and the registered serial line
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            tx_state    <= IDLE;
            tx_shift    <= '0;
            tx_bit_cnt  <= '0;
            tx_stop_cnt <= '0;
            tx_line     <= 1'b1;
        end else begin
            tx_state    <= tx_state_next;
            tx_shift    <= tx_shift_next;
            tx_bit_cnt  <= tx_bit_next;
            tx_stop_cnt <= tx_stop_next;
            tx_line     <= tx_line_next;
        end
    end

    // Transmit sequencing: accept a byte, then start, data LSB first, stop bits
    always_comb begin
        tx_state_next = tx_state;
        tx_shift_next = tx_shift;
        tx_bit_next   = tx_bit_cnt;
        tx_stop_next  = tx_stop_cnt;
        tx_line_next  = tx_line;
        tx_load       = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_line_next = 1'b1;
                if (i_we) begin
                    tx_shift_next = i_data;
                    tx_line_next  = 1'b0;
                    tx_load       = 1'b1;
                    tx_state_next = START;
                end
            end
            START: begin
                if (tx_tick) begin
                    tx_line_next  = tx_shift[0];
                    tx_shift_next = {1'b0, tx_shift[WIDTH_DATA-1:1]};
                    tx_bit_next   = '0;
                    tx_load       = 1'b1;
                    tx_state_next = DATA;
                end
            end
            DATA: begin
                if (tx_tick) begin
                    tx_load = 1'b1;
                    if (tx_bit_cnt == LAST_BIT) begin
                        tx_line_next  = 1'b1;
                        tx_stop_next  = '0;
                        tx_state_next = STOP;
                    end else begin
                        tx_line_next  = tx_shift[0];
                        tx_shift_next = {1'b0, tx_shift[WIDTH_DATA-1:1]};
                        tx_bit_next   = tx_bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tx_tick) begin
                    if (tx_stop_cnt == LAST_STOP) begin
                        tx_state_next = IDLE;
                    end else begin
                        tx_stop_next = tx_stop_cnt + 1'b1;
                        tx_load      = 1'b1;
                    end
                end
            end
            default: tx_state_next = IDLE;
        endcase
    end

    assign o_tx  = tx_line;
    assign o_mty = (tx_state == IDLE);

    // ---------------------------------------------------------------- RX
    logic                  rx_meta, rx_sync;
    uart_state_t           rx_state, rx_state_next;
    logic [WIDTH_DATA-1:0] rx_shift, rx_shift_next;
    logic [WIDTH_BIT-1:0]  rx_bit_cnt, rx_bit_next;
    logic                  rx_wait, rx_wait_next;
    logic [WIDTH_DATA-1:0] data_reg, data_next;
    logic                  rdy_reg, rdy_next;
    logic                  rx_load;
    logic [WIDTH_CLK-1:0]  rx_load_val;
    logic                  rx_tick;
    logic                  stop_sample;
`ifdef UART_FRAME_CHECK_EN
    logic                  ferr_reg, ferr_next;
`endif

    uart_baud_cnt #(.WIDTH_CLK(WIDTH_CLK)) u_rx_baud (
        .clk      (i_clk),
        .rst_n    (i_nrst),
        .load     (rx_load),
        .load_val (rx_load_val),
        .tick     (rx_tick)
    );

    // Two-flop synchronizer for the asynchronous receive pin, idling high
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    // Receive state plus the byte and valid flag presented to the host
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rx_state   <= IDLE;
            rx_shift   <= '0;
            rx_bit_cnt <= '0;
            rx_wait    <= 1'b0;
            data_reg   <= '0;
            rdy_reg    <= 1'b0;
`ifdef UART_FRAME_CHECK_EN
            ferr_reg   <= 1'b0;
`endif
        end else begin
            rx_state   <= rx_state_next;
            rx_shift   <= rx_shift_next;
            rx_bit_cnt <= rx_bit_next;
            rx_wait    <= rx_wait_next;
            data_reg   <= data_next;
            rdy_reg    <= rdy_next;
`ifdef UART_FRAME_CHECK_EN
            ferr_reg   <= ferr_next;
`endif
        end
    end

    // Receive sequencing: centre the start bit, sample data at bit centres, then stop
    always_comb begin
        rx_state_next = rx_state;
        rx_shift_next = rx_shift;
        rx_bit_next   = rx_bit_cnt;
        rx_wait_next  = rx_wait;
        rx_load       = 1'b0;
        rx_load_val   = BIT_LOAD;
        stop_sample   = 1'b0;
        case (rx_state)
            IDLE: begin
                if (rx_wait) begin
                    if (rx_sync) begin
                        rx_wait_next = 1'b0;
                    end
                end else if (!rx_sync) begin
                    rx_load       = 1'b1;
                    rx_load_val   = MID_LOAD;
                    rx_state_next = START;
                end
            end
            START: begin
                if (rx_tick) begin
                    if (rx_sync) begin
                        rx_state_next = IDLE;
                    end else begin
                        rx_load       = 1'b1;
                        rx_bit_next   = '0;
                        rx_state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_tick) begin
                    rx_shift_next = {rx_sync, rx_shift[WIDTH_DATA-1:1]};
                    rx_load       = 1'b1;
                    if (rx_bit_cnt == LAST_BIT) begin
                        rx_state_next = STOP;
                    end else begin
                        rx_bit_next = rx_bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (rx_tick) begin
                    stop_sample   = 1'b1;
                    rx_wait_next  = 1'b1;
                    rx_state_next = IDLE;
                end
            end
            default: rx_state_next = IDLE;
        endcase
    end

    // Host handshake: a read clears valid, a completed frame sets it and wins
    always_comb begin
        data_next = data_reg;
        rdy_next  = rdy_reg;
`ifdef UART_FRAME_CHECK_EN
        ferr_next = 1'b0;
`endif
        if (rdy_reg && i_re) begin
            rdy_next = 1'b0;
        end
        if (stop_sample) begin
`ifdef UART_FRAME_CHECK_EN
            if (rx_sync) begin
                data_next = rx_shift;
                rdy_next  = 1'b1;
            end else begin
                ferr_next = 1'b1;
            end
`else
            data_next = rx_shift;
            rdy_next  = 1'b1;
`endif
        end
    end

    assign o_data = data_reg;
    assign o_rdy  = rdy_reg;
`ifdef UART_FRAME_CHECK_EN
    assign o_ferr = ferr_reg;
`endif

endmodule

// File: tb/tb_uart_top.sv
// Self-checking bench for uart_top: reset, transmit waveform, back-to-back
// writes, mid-frame reset, glitch rejection, overrun, stop-bit handling and a
// TX->RX loopback with a byte scoreboard.
`timescale 1ns/1ps
module tb_uart_top;

    localparam int WIDTH_DATA   = 8;
    localparam int NB_STOP      = 2;
    localparam int WIDTH_CLK    = 9;
    localparam int CLK_SIZE     = 434;
    localparam int FRAME_CYCLES = (1 + WIDTH_DATA + NB_STOP) * CLK_SIZE;
    localparam int LOOP_DELAY   = 147;
    localparam int LOOP_CYCLES  = 50000;

    logic                  i_clk     = 1'b0;
    logic                  i_nrst    = 1'b1;
    logic                  rx_drv    = 1'b1;
    logic                  we_drv    = 1'b0;
    logic                  re_drv    = 1'b0;
    logic                  loop_mode = 1'b0;
    logic [WIDTH_DATA-1:0] i_data    = '0;
    logic                  i_rx, i_we, i_re;
    logic                  o_tx, o_rdy, o_mty;
    logic [WIDTH_DATA-1:0] o_data;
`ifdef UART_FRAME_CHECK_EN
    logic                  o_ferr;
`endif
    logic [LOOP_DELAY-1:0] tx_hist = '1;

    int                    checks      = 0;
    int                    errors      = 0;
    int                    rdy_rises   = 0;
    int                    ferr_cycles = 0;
    logic                  last_rdy    = 1'b0;
    logic [WIDTH_DATA-1:0] sb[$];
    logic                  tx_bits[$];

    assign i_rx = loop_mode ? tx_hist[LOOP_DELAY-1] : rx_drv;
    assign i_we = loop_mode ? (o_mty & we_drv) : we_drv;
    assign i_re = loop_mode ? o_rdy : re_drv;

    always #10 i_clk = ~i_clk;

    // Delay line from o_tx back to i_rx, roughly 2.94 us at 50 MHz
    always @(posedge i_clk) begin
        tx_hist <= {tx_hist[LOOP_DELAY-2:0], o_tx};
    end

    uart_top #(
        .WIDTH_DATA (WIDTH_DATA),
        .NB_STOP    (NB_STOP),
        .WIDTH_CLK  (WIDTH_CLK),
        .CLK_SIZE   (CLK_SIZE)
    ) dut (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_rx   (i_rx),
        .o_tx   (o_tx),
        .o_data (o_data),
        .o_rdy  (o_rdy),
        .i_re   (i_re),
        .o_mty  (o_mty),
        .i_we   (i_we),
        .i_data (i_data)
`ifdef UART_FRAME_CHECK_EN
        ,
        .o_ferr (o_ferr)
`endif
    );

    task automatic step();
        @(negedge i_clk);
        if (o_rdy && !last_rdy) rdy_rises++;
        last_rdy = o_rdy;
`ifdef UART_FRAME_CHECK_EN
        if (o_ferr) ferr_cycles++;
`endif
    endtask

    task automatic send_frame(input logic [WIDTH_DATA-1:0] b, input logic stop_val);
        rx_drv = 1'b0;
        repeat (CLK_SIZE) step();
        for (int i = 0; i < WIDTH_DATA; i++) begin
            rx_drv = b[i];
            repeat (CLK_SIZE) step();
        end
        rx_drv = stop_val;
        repeat (CLK_SIZE) step();
        rx_drv = 1'b1;
        repeat (CLK_SIZE) step();
    endtask

    task automatic test_reset();
        #1 i_nrst = 1'b0;
        repeat (3) step();
        checks++; if (o_tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", o_tx); end
        checks++; if (o_mty !== 1'b1) begin errors++; $display("[TB] FAIL reset_mty: got %b expected 1", o_mty); end
        checks++; if (o_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdy: got %b expected 0", o_rdy); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", o_data); end
`ifdef UART_FRAME_CHECK_EN
        checks++; if (o_ferr !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b expected 0", o_ferr); end
`endif
        i_nrst = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_single_tx();
        int   c;
        logic exp_bit;
        i_data = 8'hA5;
        we_drv = 1'b1;
        tx_bits.push_back(1'b0);
        for (int i = 0; i < WIDTH_DATA; i++) tx_bits.push_back(i_data[i]);
        for (int i = 0; i < NB_STOP; i++) tx_bits.push_back(1'b1);
        step();
        we_drv = 1'b0;
        c = 0;
        while (o_mty === 1'b0 && c < FRAME_CYCLES + 100) begin
            if (c % CLK_SIZE == CLK_SIZE / 2 && tx_bits.size() != 0) begin
                exp_bit = tx_bits.pop_front();
                checks++;
                if (o_tx !== exp_bit) begin
                    errors++;
                    $display("[TB] FAIL tx_bit%0d: got %b expected %b", c / CLK_SIZE, o_tx, exp_bit);
                end
            end
            c++;
            step();
        end
        checks++; if (c != FRAME_CYCLES) begin errors++; $display("[TB] FAIL tx_busy_len: got %0d expected %0d", c, FRAME_CYCLES); end
        checks++; if (tx_bits.size() != 0) begin errors++; $display("[TB] FAIL tx_bits_left: got %0d expected 0", tx_bits.size()); end
    endtask

    task automatic test_back_to_back();
        int c;
        i_data = 8'h11;
        we_drv = 1'b1;
        step();
        c = 0;
        while (o_mty !== 1'b1 && c < FRAME_CYCLES + 100) begin
            c++;
            step();
        end
        checks++; if (c != FRAME_CYCLES) begin errors++; $display("[TB] FAIL b2b_busy_len: got %0d expected %0d", c, FRAME_CYCLES); end
        checks++; if (o_tx !== 1'b1) begin errors++; $display("[TB] FAIL b2b_idle_tx: got %b expected 1", o_tx); end
        i_data = 8'h00;
        step();
        checks++; if (o_mty !== 1'b0) begin errors++; $display("[TB] FAIL b2b_mty: got %b expected 0", o_mty); end
        checks++; if (o_tx !== 1'b0) begin errors++; $display("[TB] FAIL b2b_start: got %b expected 0", o_tx); end
        we_drv = 1'b0;
        repeat (1000) step();
        checks++; if (o_tx !== 1'b0) begin errors++; $display("[TB] FAIL abort_pre_tx: got %b expected 0", o_tx); end
        i_nrst = 1'b0;
        #1;
        checks++; if (o_tx !== 1'b1) begin errors++; $display("[TB] FAIL abort_tx: got %b expected 1", o_tx); end
        checks++; if (o_mty !== 1'b1) begin errors++; $display("[TB] FAIL abort_mty: got %b expected 1", o_mty); end
        step();
        i_nrst = 1'b1;
        repeat (CLK_SIZE) step();
        checks++; if (o_tx !== 1'b1 || o_mty !== 1'b1) begin errors++; $display("[TB] FAIL abort_idle: got tx=%b mty=%b expected 1 1", o_tx, o_mty); end
    endtask

    task automatic test_glitch();
        int r0;
        r0 = rdy_rises;
        rx_drv = 1'b0;
        repeat (100) step();
        rx_drv = 1'b1;
        repeat (600) step();
        checks++; if (rdy_rises != r0 || o_rdy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_rdy: got rises=%0d rdy=%b expected 0 0", rdy_rises - r0, o_rdy); end
    endtask

    task automatic test_overrun();
        int r0;
        logic [WIDTH_DATA-1:0] exp;
        re_drv = 1'b0;
        r0 = rdy_rises;
        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        exp = sb.pop_front();
        checks++; if (rdy_rises != r0 + 1) begin errors++; $display("[TB] FAIL ovr_first_rise: got %0d expected 1", rdy_rises - r0); end
        checks++; if (o_data !== exp) begin errors++; $display("[TB] FAIL ovr_first_data: got %h expected %h", o_data, exp); end
        sb.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        exp = sb.pop_front();
        checks++; if (o_rdy !== 1'b1 || rdy_rises != r0 + 1) begin errors++; $display("[TB] FAIL ovr_rdy: got rdy=%b rises=%0d expected 1 1", o_rdy, rdy_rises - r0); end
        checks++; if (o_data !== exp) begin errors++; $display("[TB] FAIL ovr_data: got %h expected %h", o_data, exp); end
        re_drv = 1'b1;
        step();
        re_drv = 1'b0;
        checks++; if (o_rdy !== 1'b0) begin errors++; $display("[TB] FAIL ovr_read_rdy: got %b expected 0", o_rdy); end
        checks++; if (o_data !== exp) begin errors++; $display("[TB] FAIL ovr_read_hold: got %h expected %h", o_data, exp); end
    endtask

    task automatic test_frame_check();
        int r0;
        int f0;
        r0 = rdy_rises;
        f0 = ferr_cycles;
        send_frame(8'h55, 1'b0);
`ifdef UART_FRAME_CHECK_EN
        checks++; if (ferr_cycles - f0 != 1) begin errors++; $display("[TB] FAIL ferr_pulse: got %0d cycles expected 1", ferr_cycles - f0); end
        checks++; if (o_rdy !== 1'b0 || rdy_rises != r0) begin errors++; $display("[TB] FAIL ferr_rdy: got rdy=%b rises=%0d expected 0 0", o_rdy, rdy_rises - r0); end
        checks++; if (o_data !== 8'hC3) begin errors++; $display("[TB] FAIL ferr_data: got %h expected c3", o_data); end
`else
        checks++; if (o_rdy !== 1'b1 || rdy_rises != r0 + 1) begin errors++; $display("[TB] FAIL badstop_rdy: got rdy=%b rises=%0d expected 1 1", o_rdy, rdy_rises - r0); end
        checks++; if (o_data !== 8'h55) begin errors++; $display("[TB] FAIL badstop_data: got %h expected 55", o_data); end
        checks++; if (ferr_cycles != f0) begin errors++; $display("[TB] FAIL badstop_ferr: got %0d expected 0", ferr_cycles - f0); end
        re_drv = 1'b1;
        step();
        re_drv = 1'b0;
`endif
        repeat (10) step();
    endtask

    task automatic test_loopback();
        int   cyc    = 0;
        int   frames = 0;
        int   pushes = 0;
        logic pend   = 1'b0;
        logic prev   = 1'b0;
        logic [WIDTH_DATA-1:0] exp;
        i_data    = 8'($urandom);
        we_drv    = 1'b0;
        loop_mode = 1'b1;
        while (cyc < LOOP_CYCLES || (sb.size() != 0 && cyc < LOOP_CYCLES + FRAME_CYCLES + 1000)) begin
            step();
            cyc++;
            if (pend) begin
                i_data = 8'($urandom);
                pend   = 1'b0;
            end
            if (o_rdy) begin
                frames++;
                checks++;
                if (prev) begin
                    errors++;
                    $display("[TB] FAIL loop_rdy_width: got 2+ cycles expected 1 at frame %0d", frames);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL loop_unexpected: got %h expected none", o_data);
                end else begin
                    exp = sb.pop_front();
                    if (o_data !== exp) begin
                        errors++;
                        $display("[TB] FAIL loop_data%0d: got %h expected %h", frames, o_data, exp);
                    end
                end
            end
            prev   = o_rdy;
            we_drv = (cyc < LOOP_CYCLES);
            if (we_drv && o_mty) begin
                sb.push_back(i_data);
                pushes++;
                pend = 1'b1;
            end
        end
        checks++; if (frames != pushes) begin errors++; $display("[TB] FAIL loop_frames: got %0d expected %0d", frames, pushes); end
        checks++; if (pushes < 10) begin errors++; $display("[TB] FAIL loop_writes: got %0d expected >=10", pushes); end
        we_drv    = 1'b0;
        loop_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_back_to_back();
        test_glitch();
        test_overrun();
        test_frame_check();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
